temporal_operand_sequencer: RTL and testbench

Front-end controller for `signed_temporal_mult`. It accepts full-precision operand pairs over a valid/ready handshake and splits each operand into A_WIDTH- and B_WIDTH-bit slices. It then issues one slice pair per cycle, with matching shift, sign-mode and accumulator-clear controls. It flags when the downstream accumulator holds a finished product or dot-product result.

---
 rtl/temporal_operand_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_temporal_operand_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_operand_sequencer.sv
// rtl/temporal_operand_sequencer.sv - operand slicer and control sequencer for signed_temporal_mult
//
// Accepts full-precision operand pairs over a valid/ready handshake and issues
// one (a slice, b slice) pair per cycle. The b slice index is the outer loop
// and the a slice index is the inner loop. Each slice carries a shift, sign
// modes and an accumulator clear/load. acc_valid pulses when the downstream
// accumulator holds a finished result.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   in_valid, in_ready               operand pair handshake
//   in_a, in_b                       full-width operands
//   a_prec, b_prec                   slice count minus one (clamped to maximum)
//   a_sign, b_sign                   operand signedness
//   in_first, in_last                accumulation start / end markers
//   a, b, shift, sel                 registered slice controls to the multiplier
//   a_sign_mode, b_sign_mode         registered slice signedness
//   acc_valid                        registered one-cycle result flag
//   busy_cycles, pair_count          statistics (only with TEMPORAL_SEQ_STATS_EN)
//
// Optional feature macro: TEMPORAL_SEQ_STATS_EN

module temporal_operand_sequencer #(
  parameter int A_WIDTH       = 2,
  parameter int B_WIDTH       = 4,
  parameter int MAX_A_WIDTH   = 8,
  parameter int MAX_B_WIDTH   = 8,
  parameter int MIN_WIDTH     = (A_WIDTH < B_WIDTH) ? A_WIDTH : B_WIDTH,
  parameter int SHIFTER_WIDTH = 4,
  parameter int APW = ((MAX_A_WIDTH / A_WIDTH) > 1) ? $clog2(MAX_A_WIDTH / A_WIDTH) : 1,
  parameter int BPW = ((MAX_B_WIDTH / B_WIDTH) > 1) ? $clog2(MAX_B_WIDTH / B_WIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAX_A_WIDTH-1:0]   in_a,
  input  logic [MAX_B_WIDTH-1:0]   in_b,
  input  logic [APW-1:0]           a_prec,
  input  logic [BPW-1:0]           b_prec,
  input  logic                     a_sign,
  input  logic                     b_sign,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic [A_WIDTH-1:0]       a,
  output logic [B_WIDTH-1:0]       b,
  output logic [SHIFTER_WIDTH-1:0] shift,
  output logic                     sel,
  output logic                     a_sign_mode,
  output logic                     b_sign_mode,
  output logic                     acc_valid
`ifdef TEMPORAL_SEQ_STATS_EN
  ,
  output logic [31:0]              busy_cycles,
  output logic [31:0]              pair_count
`endif
);

  localparam int A_SLICES = MAX_A_WIDTH / A_WIDTH;
  localparam int B_SLICES = MAX_B_WIDTH / B_WIDTH;
  localparam logic [APW-1:0] A_IDX_MAX = APW'(A_SLICES - 1);
  localparam logic [BPW-1:0] B_IDX_MAX = BPW'(B_SLICES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [MAX_A_WIDTH-1:0]   a_hold;
  logic [MAX_B_WIDTH-1:0]   b_hold;
  logic [APW-1:0]           a_prec_hold, a_prec_clamped, i_idx, i_next;
  logic [BPW-1:0]           b_prec_hold, b_prec_clamped, j_idx, j_next;
  logic                     a_sign_hold, b_sign_hold, first_hold, last_hold;
  logic                     last_slice, accept;
  logic                     done_pending;

  logic [A_WIDTH-1:0]       a_nx;
  logic [B_WIDTH-1:0]       b_nx;
  logic [SHIFTER_WIDTH-1:0] shift_nx;
  logic                     sel_nx, a_mode_nx, b_mode_nx;

  // Precision selects wider than the slice count are clamped to the top slice.
  always_comb begin
    a_prec_clamped = (int'(a_prec) >= A_SLICES) ? A_IDX_MAX : a_prec;
    b_prec_clamped = (int'(b_prec) >= B_SLICES) ? B_IDX_MAX : b_prec;
  end

  // Ready in the last slice cycle lets the next pair start with no bubble.
  assign last_slice = (state == RUN) && (i_idx == a_prec_hold) && (j_idx == b_prec_hold);
  assign in_ready   = (state == IDLE) || last_slice;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_next = state;
    i_next     = i_idx;
    j_next     = j_idx;
    a_nx       = '0;
    b_nx       = '0;
    shift_nx   = '0;
    sel_nx     = 1'b0;
    a_mode_nx  = 1'b0;
    b_mode_nx  = 1'b0;

    if (state == RUN) begin
      a_nx      = a_hold[i_idx*A_WIDTH +: A_WIDTH];
      b_nx      = b_hold[j_idx*B_WIDTH +: B_WIDTH];
      shift_nx  = SHIFTER_WIDTH'((int'(i_idx) * A_WIDTH + int'(j_idx) * B_WIDTH) / MIN_WIDTH);
      sel_nx    = first_hold && (i_idx == '0) && (j_idx == '0);
      // Only the most significant slice of a signed operand is signed.
      a_mode_nx = a_sign_hold && (i_idx == a_prec_hold);
      b_mode_nx = b_sign_hold && (j_idx == b_prec_hold);

      if (i_idx == a_prec_hold) begin
        i_next = '0;
        j_next = j_idx + 1'b1;
      end else begin
        i_next = i_idx + 1'b1;
      end

      if (last_slice) begin
        state_next = IDLE;
      end
    end

    if (accept) begin
      state_next = RUN;
      i_next     = '0;
      j_next     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      i_idx        <= '0;
      j_idx        <= '0;
      a_hold       <= '0;
      b_hold       <= '0;
      a_prec_hold  <= '0;
      b_prec_hold  <= '0;
      a_sign_hold  <= 1'b0;
      b_sign_hold  <= 1'b0;
      first_hold   <= 1'b0;
      last_hold    <= 1'b0;
      a            <= '0;
      b            <= '0;
      shift        <= '0;
      sel          <= 1'b0;
      a_sign_mode  <= 1'b0;
      b_sign_mode  <= 1'b0;
      done_pending <= 1'b0;
      acc_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      i_idx       <= i_next;
      j_idx       <= j_next;
      a           <= a_nx;
      b           <= b_nx;
      shift       <= shift_nx;
      sel         <= sel_nx;
      a_sign_mode <= a_mode_nx;
      b_sign_mode <= b_mode_nx;
      // The last slice leaves this block one cycle from now and lands in the
      // accumulator one cycle after that, hence the two-stage flag.
      done_pending <= last_slice && last_hold;
      acc_valid    <= done_pending;
      if (accept) begin
        a_hold      <= in_a;
        b_hold      <= in_b;
        a_prec_hold <= a_prec_clamped;
        b_prec_hold <= b_prec_clamped;
        a_sign_hold <= a_sign;
        b_sign_hold <= b_sign;
        first_hold  <= in_first;
        last_hold   <= in_last;
      end
    end
  end

`ifdef TEMPORAL_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cycles <= '0;
      pair_count  <= '0;
    end else begin
      if (state == RUN) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
      if (accept) begin
        pair_count <= pair_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_temporal_operand_sequencer.sv
// tb/tb_temporal_operand_sequencer.sv - scoreboard bench for temporal_operand_sequencer
module tb_temporal_operand_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] a_prec;
  logic [0:0] b_prec;
  logic       a_sign;
  logic       b_sign;
  logic       in_first;
  logic       in_last;
  logic [1:0] a;
  logic [3:0] b;
  logic [3:0] shift;
  logic       sel;
  logic       a_sign_mode;
  logic       b_sign_mode;
  logic       acc_valid;
`ifdef TEMPORAL_SEQ_STATS_EN
  logic [31:0] busy_cycles;
  logic [31:0] pair_count;
`endif

  temporal_operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .a_prec      (a_prec),
    .b_prec      (b_prec),
    .a_sign      (a_sign),
    .b_sign      (b_sign),
    .in_first    (in_first),
    .in_last     (in_last),
    .a           (a),
    .b           (b),
    .shift       (shift),
    .sel         (sel),
    .a_sign_mode (a_sign_mode),
    .b_sign_mode (b_sign_mode),
    .acc_valid   (acc_valid)
`ifdef TEMPORAL_SEQ_STATS_EN
    ,
    .busy_cycles (busy_cycles),
    .pair_count  (pair_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Expected slice tuples {a, b, shift, sel, a_sign_mode, b_sign_mode} and results.
  logic [12:0] exp_s[$];
  longint      exp_r[$];

  function automatic void check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
  endfunction

  function automatic logic [12:0] pack(input int va, input int vb, input int sh,
                                       input bit s, input bit am, input bit bm);
    logic [1:0] pa;
    logic [3:0] pb;
    logic [3:0] ps;
    pa = 2'(va);
    pb = 4'(vb);
    ps = 4'(sh);
    return {pa, pb, ps, s, am, bm};
  endfunction

  // Reference slicing: a slice i is bits [2i+1:2i], b slice j is bits [4j+3:4j],
  // shift in 2-bit units is i + 2j.
  task automatic push_model(input logic [7:0] va, input logic [7:0] vb, input int ap,
                            input int bp, input bit as, input bit bs, input bit f);
    for (int k = 0; k < (ap + 1) * (bp + 1); k++) begin
      int i;
      int j;
      i = k % (ap + 1);
      j = k / (ap + 1);
      exp_s.push_back(pack(int'((va >> (2 * i)) & 8'h03), int'((vb >> (4 * j)) & 8'h0f),
                           i + 2 * j, f && (k == 0), as && (i == ap), bs && (j == bp)));
    end
  endtask

  // Drives a pair and returns how many sampled cycles it waited for in_ready.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] ap,
                      input logic bp, input bit as, input bit bs, input bit f,
                      input bit l, output int waited);
    bit ok;
    in_valid = 1'b1;
    in_a     = va;
    in_b     = vb;
    a_prec   = ap;
    b_prec   = bp;
    a_sign   = as;
    b_sign   = bs;
    in_first = f;
    in_last  = l;
    ok       = 1'b0;
    waited   = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Monitor: schedules slice/result cycles from observed handshakes and checks
  // every cycle against the scoreboard, while modelling the downstream accumulator.
  logic [63:0] sched;
  logic [63:0] acc_sched;
  longint      acc_m;

  initial begin
    sched     = '0;
    acc_sched = '0;
    acc_m     = 0;
  end

  always @(negedge clk) begin : monitor
    longint      pa;
    longint      pb;
    logic [12:0] got;
    logic [12:0] want;
    int          n;
    if (!reset) begin
      sched     = '0;
      acc_sched = '0;
      acc_m     = 0;
      exp_s.delete();
      exp_r.delete();
    end else begin
      check("acc_valid", longint'(acc_valid), longint'(acc_sched[0]));
      if (acc_sched[0]) begin
        if (exp_r.size() == 0) check("result_queue_empty", 0, 1);
        else check("acc_result", acc_m, exp_r.pop_front());
      end
      got = {a, b, shift, sel, a_sign_mode, b_sign_mode};
      if (sched[0]) begin
        if (exp_s.size() == 0) check("slice_queue_empty", 0, 1);
        else begin
          want = exp_s.pop_front();
          check("slice", longint'(got), longint'(want));
        end
      end else begin
        check("idle_outputs", longint'(got), 0);
      end
      pa = a_sign_mode ? longint'($signed(a)) : longint'(a);
      pb = b_sign_mode ? longint'($signed(b)) : longint'(b);
      if (sel) acc_m = (pa * pb) <<< (2 * int'(shift));
      else acc_m = acc_m + ((pa * pb) <<< (2 * int'(shift)));
      sched     = sched >> 1;
      acc_sched = acc_sched >> 1;
      if (in_valid && in_ready) begin
        n = (int'(a_prec) + 1) * (int'(b_prec) + 1);
        sched = sched | (((64'd1 << n) - 64'd1) << 1);
        if (in_last) acc_sched = acc_sched | (64'd1 << (n + 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    a_prec   = '0;
    b_prec   = '0;
    a_sign   = 1'b0;
    b_sign   = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_outputs", longint'({a, b, shift, sel, a_sign_mode, b_sign_mode, acc_valid}), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned full precision, hand-computed slices: 200 x 100.
    exp_s.push_back(pack(0, 4, 0, 1, 0, 0));
    exp_s.push_back(pack(2, 4, 1, 0, 0, 0));
    exp_s.push_back(pack(0, 4, 2, 0, 0, 0));
    exp_s.push_back(pack(3, 4, 3, 0, 0, 0));
    exp_s.push_back(pack(0, 6, 2, 0, 0, 0));
    exp_s.push_back(pack(2, 6, 3, 0, 0, 0));
    exp_s.push_back(pack(0, 6, 4, 0, 0, 0));
    exp_s.push_back(pack(3, 6, 5, 0, 0, 0));
    exp_r.push_back(20000);
    send(8'd200, 8'd100, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Signed full precision: -3 x 5.
    push_model(8'hfd, 8'd5, 3, 1, 1'b1, 1'b1, 1'b1);
    exp_r.push_back(-15);
    send(8'hfd, 8'd5, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Low precision: 2'b10 signed x 7 unsigned.
    push_model(8'h02, 8'h07, 0, 0, 1'b1, 1'b0, 1'b1);
    exp_r.push_back(-14);
    send(8'h02, 8'h07, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Dot product back to back: (3,4) . (5,6) = 39.
    push_model(8'd3, 8'd5, 3, 1, 1'b0, 1'b0, 1'b1);
    push_model(8'd4, 8'd6, 3, 1, 1'b0, 1'b0, 1'b0);
    exp_r.push_back(39);
    send(8'd3, 8'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, w);
    send(8'd4, 8'd6, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w);
    check("b2b_ready_wait", w, 7);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset on the 4th slice cycle, then a fresh pair: 7 x 9.
    push_model(8'd200, 8'd100, 3, 1, 1'b0, 1'b0, 1'b1);
    exp_r.push_back(20000);
    send(8'd200, 8'd100, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_reset_in_ready", longint'(in_ready), 1);
    check("midrun_reset_outputs", longint'({a, b, shift, sel, a_sign_mode, b_sign_mode, acc_valid}), 0);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    push_model(8'd7, 8'd9, 3, 1, 1'b0, 1'b0, 1'b1);
    exp_r.push_back(63);
    send(8'd7, 8'd9, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;

    check("slices_left", exp_s.size(), 0);
    check("results_left", exp_r.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
